// File: rtl/sdp_pkg.sv
// Shared types, character codes and segment patterns for the 7-segment scan driver.
package sdp_pkg;

  localparam logic [4:0] SDP_CH_H     = 5'h10;
  localparam logic [4:0] SDP_CH_L     = 5'h11;
  localparam logic [4:0] SDP_CH_O     = 5'h12;
  localparam logic [4:0] SDP_CH_P     = 5'h13;
  localparam logic [4:0] SDP_CH_DASH  = 5'h14;
  localparam logic [4:0] SDP_CH_UNDER = 5'h15;
  localparam logic [4:0] SDP_CH_BLANK = 5'h1F;

  localparam logic [6:0] SDP_SEG_OFF  = 7'h7F;

  typedef enum logic {ST_LIT, ST_DEAD} sdp_state_e;

  typedef struct packed {
    logic       blink;
    logic       dp;
    logic [4:0] code;
  } sdp_digit_t;

  localparam sdp_digit_t SDP_DIGIT_BLANK = '{blink: 1'b0, dp: 1'b0, code: SDP_CH_BLANK};

  // Active-low {g,f,e,d,c,b,a}; anything unmapped is dark.
  function automatic logic [6:0] sdp_seg_n(input logic [4:0] code);
    case (code)
      5'h00:        return 7'b1000000;
      5'h01:        return 7'b1111001;
      5'h02:        return 7'b0100100;
      5'h03:        return 7'b0110000;
      5'h04:        return 7'b0011001;
      5'h05:        return 7'b0010010;
      5'h06:        return 7'b0000010;
      5'h07:        return 7'b1111000;
      5'h08:        return 7'b0000000;
      5'h09:        return 7'b0010000;
      5'h0A:        return 7'b0001000;
      5'h0B:        return 7'b0000011;
      5'h0C:        return 7'b1000110;
      5'h0D:        return 7'b0100001;
      5'h0E:        return 7'b0000110;
      5'h0F:        return 7'b0001110;
      SDP_CH_H:     return 7'b0001001;
      SDP_CH_L:     return 7'b1000111;
      SDP_CH_O:     return 7'b0100011;
      SDP_CH_P:     return 7'b0001100;
      SDP_CH_DASH:  return 7'b0111111;
      SDP_CH_UNDER: return 7'b1110111;
      default:      return SDP_SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/sdp_char_rom.sv
// Character code to active-low segment pattern lookup.
module sdp_char_rom
  import sdp_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg_n
);

  always_comb seg_n = sdp_seg_n(code);

endmodule

// File: rtl/sdp_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: N digits, dp, blink,
// frame-synchronous buffer swap and per-slot dead time against ghosting.
module sdp_scan_driver
  import sdp_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] char_bus,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  output logic [NUM_DIGITS-1:0]   sdpsel,
  output logic [7:0]              sdpdisp,
  output logic                    frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] LIT_LAST = CW'(SCAN_DIV - DEAD_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  sdp_state_e                  st;
  logic [CW-1:0]               cnt;
  logic [DW-1:0]               digit;
  logic [FW-1:0]               fcnt;
  logic                        phase;
  sdp_digit_t [NUM_DIGITS-1:0] in_buf, pend_buf, act_buf, cur_buf;
  sdp_digit_t                  cur_dig;
  logic [6:0]                  seg_n;
  logic                        wrap, blanked;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_in
    assign in_buf[k] = '{blink: blink_in[k], dp: dp_in[k], code: char_bus[5*k +: 5]};
  end

  // frame_done marks the first cycle of digit 0: the swap point, with a
  // same-cycle load bypassed straight into the frame being started.
  always_comb begin
    cur_buf = act_buf;
    if (frame_done) cur_buf = load ? in_buf : pend_buf;
  end

  assign cur_dig = cur_buf[digit];
  assign wrap    = enable && (cnt == CNT_LAST) && (digit == DIG_LAST);
  assign blanked = (cur_dig.blink && phase) || (seg_n == SDP_SEG_OFF);

  sdp_char_rom u_rom (
    .code  (cur_dig.code),
    .seg_n (seg_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_LIT;
      cnt        <= '0;
      digit      <= '0;
      fcnt       <= '0;
      phase      <= 1'b0;
      frame_done <= 1'b0;
      pend_buf   <= {NUM_DIGITS{SDP_DIGIT_BLANK}};
      act_buf    <= {NUM_DIGITS{SDP_DIGIT_BLANK}};
      sdpsel     <= '1;
      sdpdisp    <= 8'hFF;
    end else begin
      frame_done <= wrap;
      if (load)       pend_buf <= in_buf;
      if (frame_done) act_buf  <= cur_buf;

      if (enable) begin
        if (cnt == CNT_LAST) begin
          cnt   <= '0;
          st    <= ST_LIT;
          digit <= (digit == DIG_LAST) ? '0 : digit + DW'(1);
        end else begin
          cnt <= cnt + CW'(1);
          if (cnt == LIT_LAST) st <= ST_DEAD;
        end
      end

      if (wrap) begin
        if (fcnt == FRM_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end

      if (!enable || st == ST_DEAD) begin
        sdpsel  <= '1;
        sdpdisp <= 8'hFF;
      end else begin
        sdpsel  <= ~(NUM_DIGITS'(1) << digit);
        sdpdisp <= blanked ? 8'hFF : {~cur_dig.dp, seg_n};
      end
    end
  end

endmodule

// File: tb/tb_sdp_scan_driver.sv
// Directed bench: reset, HELLO, tear-free swap, dp/blink, enable freeze, 8-digit no-dead sweep.
module tb_sdp_scan_driver;

  logic        clk, rst_n, enable, load;
  logic [24:0] char_bus;
  logic [4:0]  dp_in, blink_in, sdpsel;
  logic [7:0]  sdpdisp;
  logic        frame_done;
  logic [7:0]  sel2, disp2;
  logic        fd2;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_d [5];

  sdp_scan_driver #(.NUM_DIGITS(5), .SCAN_DIV(4), .DEAD_CYCLES(1), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .char_bus(char_bus),
    .dp_in(dp_in), .blink_in(blink_in), .sdpsel(sdpsel), .sdpdisp(sdpdisp),
    .frame_done(frame_done)
  );

  sdp_scan_driver #(.NUM_DIGITS(8), .SCAN_DIV(4), .DEAD_CYCLES(0), .BLINK_FRAMES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(1'b0), .char_bus(40'h0),
    .dp_in(8'h00), .blink_in(8'h00), .sdpsel(sel2), .sdpdisp(disp2),
    .frame_done(fd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_exp(input logic [7:0] a, b, c, d, e);
    exp_d[0] = a; exp_d[1] = b; exp_d[2] = c; exp_d[3] = d; exp_d[4] = e;
  endtask

  // One 20-cycle frame; pins at iteration i reflect frame cycle i. A load is
  // raised after iteration load_at, so it lands in frame cycle load_at+1.
  task automatic run_frame(input int fr, input int load_at, input logic [24:0] cb,
                           input logic [4:0] dp, input logic [4:0] bl);
    logic [4:0] es;
    logic [7:0] ed;
    for (int i = 0; i < 20; i++) begin
      tick();
      load = 1'b0;
      if (i % 4 == 3) begin
        es = 5'h1F;
        ed = 8'hFF;
      end else begin
        es = ~(5'b00001 << (i / 4));
        ed = exp_d[i / 4];
      end
      chk($sformatf("f%0d_i%0d_sel", fr, i), {3'b000, sdpsel}, {3'b000, es});
      chk($sformatf("f%0d_i%0d_disp", fr, i), sdpdisp, ed);
      chk($sformatf("f%0d_i%0d_fd", fr, i), {7'd0, frame_done}, {7'd0, (i == 19)});
      if (i == load_at) begin
        char_bus = cb; dp_in = dp; blink_in = bl; load = 1'b1;
      end
    end
  endtask

  localparam logic [24:0] CB_HELLO = {5'h00, 5'h11, 5'h11, 5'h0E, 5'h10};
  localparam logic [24:0] CB_12345 = {5'h05, 5'h04, 5'h03, 5'h02, 5'h01};
  localparam logic [24:0] CB_MIX   = {5'h16, 5'h0A, 5'h15, 5'h14, 5'h13};

  initial begin
    int n, dead;
    logic seen;
    rst_n = 1'b0; enable = 1'b1; load = 1'b0;
    char_bus = '0; dp_in = '0; blink_in = '0;

    tick(); tick();
    chk("rst_sel", {3'b000, sdpsel}, 8'h1F);
    chk("rst_disp", sdpdisp, 8'hFF);
    chk("rst_fd", {7'd0, frame_done}, 8'h00);

    rst_n = 1'b1;
    tick(); tick();
    chk("prerst_sel", {3'b000, sdpsel}, 8'h1E);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sel", {3'b000, sdpsel}, 8'h1F);
    chk("midrst_disp", sdpdisp, 8'hFF);
    chk("midrst_sel8", sel2, 8'hFF);
    tick();
    rst_n = 1'b1;

    // frame 0 blank despite an early load; HELLO shows in frame 1
    set_exp(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_frame(0, 1, CB_HELLO, 5'b00000, 5'b00000);
    set_exp(8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0);
    run_frame(1, 8, CB_12345, 5'b00000, 5'b00000);
    set_exp(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92);
    run_frame(2, 19, CB_MIX, 5'b01000, 5'b00000);
    set_exp(8'h8C, 8'hBF, 8'hF7, 8'h08, 8'hFF);
    run_frame(3, 19, CB_HELLO, 5'b01000, 5'b00010);

    // blink phase: frames 4-5 on, 6-7 off, 8 on
    set_exp(8'h89, 8'h86, 8'hC7, 8'h47, 8'hC0);
    run_frame(4, -1, '0, '0, '0);
    run_frame(5, -1, '0, '0, '0);
    set_exp(8'h89, 8'hFF, 8'hC7, 8'h47, 8'hC0);
    run_frame(6, -1, '0, '0, '0);
    run_frame(7, -1, '0, '0, '0);
    set_exp(8'h89, 8'h86, 8'hC7, 8'h47, 8'hC0);
    run_frame(8, -1, '0, '0, '0);

    // enable low for 7 cycles with digit 0 at slot count 2
    tick(); tick();
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("en0_%0d_sel", i), {3'b000, sdpsel}, 8'h1F);
      chk($sformatf("en0_%0d_disp", i), sdpdisp, 8'hFF);
    end
    enable = 1'b1;
    tick();
    chk("resume_sel", {3'b000, sdpsel}, 8'h1E);
    chk("resume_disp", sdpdisp, 8'h89);
    tick();
    chk("resume_dead", {3'b000, sdpsel}, 8'h1F);
    tick();
    chk("resume_d1_sel", {3'b000, sdpsel}, 8'h1D);
    chk("resume_d1_disp", sdpdisp, 8'h86);

    // 8-digit, no dead time: frame period 32, select never all ones
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (fd2) seen = 1'b1;
    end
    chk("fd8_seen", {7'd0, seen}, 8'h01);
    n = 0; dead = 0; seen = 1'b0;
    while (!seen && n < 64) begin
      tick();
      n++;
      if (n == 1) chk("d8_first_sel", sel2, 8'hFE);
      if (sel2 == 8'hFF) dead++;
      if (fd2) seen = 1'b1;
    end
    chk("fd8_period", 8'(n), 8'd32);
    chk("d8_dead", 8'(dead), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
